// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - two-port (fetch/data) arbiter and sequencer onto a single-port memory
module mem_port_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic [DATA_W-1:0] dp_rdata,
  output logic              dp_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic                owner_dp_q;
  logic                we_q;
  logic                last_dp_q;
  logic                mwe_q;
  logic                if_valid_q;
  logic                dp_done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dp_rdata_q;
  logic                grant_dp;
  logic                grant_if;

  // On a tie the port that did not win last time gets the memory.
  assign grant_dp = dp_req && (!if_req || !last_dp_q);
  assign grant_if = if_req && !grant_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_dp_q <= 1'b0;
      we_q       <= 1'b0;
      last_dp_q  <= 1'b0;
      mwe_q      <= 1'b0;
      if_valid_q <= 1'b0;
      dp_done_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dp || grant_if) begin
            state_q    <= ACCESS;
            owner_dp_q <= grant_dp;
            last_dp_q  <= grant_dp;
            if (grant_dp) begin
              addr_q  <= dp_addr;
              we_q    <= dp_we;
              wdata_q <= dp_wdata;
              mwe_q   <= dp_we;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              mwe_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          state_q <= DONE;
          mwe_q   <= 1'b0;
          if (owner_dp_q) begin
            dp_done_q <= 1'b1;
            if (!we_q) dp_rdata_q <= mem_read_data;
          end else begin
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_read_data;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          if_valid_q <= 1'b0;
          dp_done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata         = if_rdata_q;
  assign if_valid         = if_valid_q;
  assign dp_rdata         = dp_rdata_q;
  assign dp_done          = dp_done_q;
  assign mem_address      = addr_q;
  assign mem_write_enable = mwe_q;
  assign mem_write_data   = wdata_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed scoreboard bench for mem_port_ctrl
module tb_mem_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_req = 1'b0;
  logic [4:0] if_addr = '0;
  logic [7:0] if_rdata;
  logic       if_valid;
  logic       dp_req = 1'b0;
  logic       dp_we = 1'b0;
  logic [4:0] dp_addr = '0;
  logic [7:0] dp_wdata = '0;
  logic [7:0] dp_rdata;
  logic       dp_done;
  logic [4:0] mem_address;
  logic       mem_write_enable;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem    [32];
  logic [7:0] shadow [32];
  logic [7:0] if_q [$];
  logic [7:0] dp_q [$];
  logic [7:0] model_if = 8'h00;
  logic [7:0] model_dp = 8'h00;

  always #5 clk = ~clk;

  mem_port_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_rdata(dp_rdata), .dp_done(dp_done),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  assign mem_read_data = mem[mem_address];

  always @(negedge clk) begin
    if (mem_write_enable) mem[mem_address] = mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each completion pops the oldest expectation for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_valid) begin
        if (if_q.size() == 0) chk("if_unexpected_valid", 1, 0);
        else begin
          model_if = if_q.pop_front();
          chk("if_rdata", {24'h0, if_rdata}, {24'h0, model_if});
          chk("if_excl_dp_done", {31'h0, dp_done}, 0);
          chk("dp_rdata_kept", {24'h0, dp_rdata}, {24'h0, model_dp});
        end
      end
      if (dp_done) begin
        if (dp_q.size() == 0) chk("dp_unexpected_done", 1, 0);
        else begin
          model_dp = dp_q.pop_front();
          chk("dp_rdata", {24'h0, dp_rdata}, {24'h0, model_dp});
          chk("if_rdata_kept", {24'h0, if_rdata}, {24'h0, model_if});
        end
      end
    end
  end

  task automatic dp_access(input logic we, input logic [4:0] a, input logic [7:0] d);
    int n;
    if (we) begin
      dp_q.push_back(dp_q.size() > 0 ? dp_q[$] : model_dp);
      shadow[a] = d;
    end else begin
      dp_q.push_back(shadow[a]);
    end
    @(negedge clk);
    dp_req = 1'b1; dp_we = we; dp_addr = a; dp_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!dp_done && n < 20);
    chk("dp_latency", n, 2);
    dp_req = 1'b0;
  endtask

  task automatic if_access(input logic [4:0] a);
    int n;
    if_q.push_back(shadow[a]);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid && n < 20);
    chk("if_latency", n, 2);
    if_req = 1'b0;
  endtask

  initial begin
    int t;
    int tv [3];
    int k;
    int t_dp1, t_if1, t_dp2, n_dp;

    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'(i * 3 + 1);
      shadow[i] = mem[i];
    end
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[31] = 8'h3C; mem[9] = 8'h11;
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];

    #2;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_mwe", {31'h0, mem_write_enable}, 0);
    chk("rst_if_valid", {31'h0, if_valid}, 0);
    chk("rst_dp_done", {31'h0, dp_done}, 0);
    chk("rst_mem_address", {27'h0, mem_address}, 0);
    chk("rst_mem_wdata", {24'h0, mem_write_data}, 0);
    chk("rst_if_rdata", {24'h0, if_rdata}, 0);
    chk("rst_dp_rdata", {24'h0, dp_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back through the other port.
    dp_access(1'b1, 5'd5, 8'hA7);
    if_access(5'd5);
    chk("mem5_written", {24'h0, mem[5]}, 32'hA7);

    // Back-to-back fetch reads with request held.
    if_q.push_back(shadow[0]); if_q.push_back(shadow[1]); if_q.push_back(shadow[2]);
    @(negedge clk);
    if_req = 1'b1; if_addr = 5'd0;
    t = 0; k = 0;
    while (k < 3 && t < 40) begin
      @(negedge clk); t++;
      if (if_valid) begin
        tv[k] = t; k++;
        if_addr = 5'(k);
      end
    end
    if_req = 1'b0;
    chk("b2b_count", k, 3);
    chk("b2b_first", tv[0], 2);
    chk("b2b_gap1", tv[1] - tv[0], 3);
    chk("b2b_gap2", tv[2] - tv[1], 3);

    // Port inputs changed during ACCESS must not disturb the latched write.
    shadow[12] = 8'h5A;
    dp_q.push_back(model_dp);
    @(negedge clk);
    dp_req = 1'b1; dp_we = 1'b1; dp_addr = 5'd12; dp_wdata = 8'h5A;
    @(posedge clk); #2;
    dp_addr = 5'd13; dp_wdata = 8'h00;
    #1;
    chk("hold_busy", {31'h0, busy}, 1);
    chk("hold_mwe", {31'h0, mem_write_enable}, 1);
    chk("hold_addr", {27'h0, mem_address}, 12);
    chk("hold_wdata", {24'h0, mem_write_data}, 32'h5A);
    t = 0;
    do begin @(negedge clk); t++; end while (!dp_done && t < 20);
    chk("hold_done_seen", {31'h0, dp_done}, 1);
    chk("hold_mwe_done", {31'h0, mem_write_enable}, 0);
    dp_req = 1'b0;
    @(negedge clk);
    chk("mem12", {24'h0, mem[12]}, 32'h5A);
    chk("mem13", {24'h0, mem[13]}, {24'h0, shadow[13]});
    @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 0);
    chk("idle_addr_hold", {27'h0, mem_address}, 12);

    // Reset pulsed during the ACCESS cycle of a write.
    dp_q.push_back(model_dp);
    @(negedge clk);
    dp_req = 1'b1; dp_we = 1'b1; dp_addr = 5'd9; dp_wdata = 8'hFF;
    @(posedge clk); #2;
    chk("rst_mid_mwe_before", {31'h0, mem_write_enable}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mwe", {31'h0, mem_write_enable}, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    chk("rst_mid_addr", {27'h0, mem_address}, 0);
    chk("rst_mid_wdata", {24'h0, mem_write_data}, 0);
    chk("rst_mid_if_rdata", {24'h0, if_rdata}, 0);
    chk("rst_mid_dp_rdata", {24'h0, dp_rdata}, 0);
    chk("rst_mid_dp_done", {31'h0, dp_done}, 0);
    @(negedge clk);
    dp_req = 1'b0;
    dp_q.delete();
    model_dp = 8'h00;
    model_if = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 0);

    // Simultaneous requests: data port first after reset, then alternate.
    dp_q.push_back(shadow[31]); dp_q.push_back(shadow[31]);
    if_q.push_back(shadow[1]);
    @(negedge clk);
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 5'd31;
    if_req = 1'b1; if_addr = 5'd1;
    t = 0; n_dp = 0; t_dp1 = 0; t_if1 = 0; t_dp2 = 0;
    while ((n_dp < 2 || if_req) && t < 40) begin
      @(negedge clk); t++;
      if (dp_done) begin
        n_dp++;
        if (n_dp == 1) t_dp1 = t; else begin t_dp2 = t; dp_req = 1'b0; end
      end
      if (if_valid) begin t_if1 = t; if_req = 1'b0; end
    end
    dp_req = 1'b0; if_req = 1'b0;
    chk("tie_dp_first", t_dp1, 2);
    chk("tie_if_second", t_if1, 5);
    chk("tie_dp_third", t_dp2, 8);
    chk("tie_dp_rdata", {24'h0, dp_rdata}, 32'h3C);

    repeat (3) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("dp_q_drained", dp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5: memory address width (32 words).
REQ-002 Parameter DATA_W, default 8: memory data width.
REQ-003 Clocking SHALL be one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 if_req  input  1  fetch-port read request, held until if_valid.
REQ-007 if_addr  input  ADDR_W  fetch-port read address.
REQ-008 if_rdata  output  DATA_W  fetch-port read data, registered.
REQ-009 if_valid  output  1  one-cycle pulse; if_rdata is valid.
REQ-010 dp_req  input  1  data-port request, held until dp_done.
REQ-011 dp_we  input  1  data-port write (1) or read (0).
REQ-012 dp_addr  input  ADDR_W  data-port address.
REQ-013 dp_wdata  input  DATA_W  data-port write data.
REQ-014 dp_rdata  output  DATA_W  data-port read data, registered.
REQ-015 dp_done  output  1  one-cycle pulse; access complete.
REQ-016 mem_address  output  ADDR_W  address to downstream memory.
REQ-017 mem_write_enable  output  1  write strobe to downstream memory.
REQ-018 mem_write_data  output  DATA_W  write data to downstream memory.
REQ-019 mem_read_data  input  DATA_W  combinational read data from memory.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS on any granted request; ACCESS->DONE always; DONE->IDLE always.
REQ-022 In IDLE, on a rising edge with a request present, the controller SHALL latch owner, address, we, wdata of the granted port into internal registers.
REQ-023 Arbitration: single requester wins; if both request, grant SHALL go to the port not granted last; last-grant register resets to fetch (data port wins first tie).
REQ-024 During ACCESS, mem_address and mem_write_data SHALL be driven from the latched registers and held stable the whole cycle.
REQ-025 mem_write_enable SHALL be 1 only during ACCESS of a data-port write, 0 in all other states (memory commits on the falling edge mid-cycle).
REQ-026 At the rising edge ending ACCESS, a read SHALL capture mem_read_data into if_rdata or dp_rdata of the owner; the other port's data register is unchanged.
REQ-027 if_valid or dp_done (owner only) SHALL be high for exactly the DONE cycle; dp_done also pulses for writes, with dp_rdata unchanged.
REQ-028 Latency: request sampled at edge k -> ACCESS cycle k+1 -> valid/done high cycle k+2; throughput one access per 3 cycles.
REQ-029 Requests and port inputs SHALL be ignored in ACCESS and DONE; a req still high in the IDLE cycle after DONE is a new request.
REQ-030 A losing requester SHALL remain pending and be granted at the next IDLE.
REQ-031 Address 31 and address 0 SHALL be handled identically; no address wrap or increment is performed.
REQ-032 When idle, mem_address SHALL hold the last accessed address.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, mem_write_enable 0, if_valid 0, dp_done 0, busy 0, mem_address 0, mem_write_data 0, if_rdata 0, dp_rdata 0, last-grant = fetch.
REQ-034 Reset asserted during ACCESS of a write SHALL drop mem_write_enable immediately; the write may not commit; after release, access resumes from IDLE.

Verification
REQ-035 dp write addr 5 data 8'hA7, then if read addr 5 -> dp_done pulse 2 cycles after request, then if_valid with if_rdata 8'hA7.
REQ-036 if_req and dp_req (read addr 31, preset 8'h3C) raised together -> dp served first (dp_rdata 8'h3C), if served next; second tie goes to if.
REQ-037 Back-to-back if reads addr 0,1,2 with req held -> one if_valid every 3 cycles, data matches preset contents.
REQ-038 dp write addr 9 data 8'hFF; rst_n pulsed low mid-ACCESS -> mem_write_enable 0 within same cycle, all outputs at reset values, FSM in IDLE.
REQ-039 Change dp_addr/dp_wdata during ACCESS -> mem_address/mem_write_data unchanged, original latched values written.
